// File: rtl/jk_bank_pkg.sv
// Shared types for the JK bank arbiter: JK op encoding, FSM states, requester ids.
package jk_bank_pkg;

    // JK op encoding: bit 1 drives j, bit 0 drives k.
    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } jk_op_t;

    // Command sequencer states; exactly one command may be in flight.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_APPLY = 2'b01,
        ST_DONE  = 2'b10
    } jk_state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop with asynchronous active-low reset.
module jk_ff_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic j,
    input  logic k,
    output logic q
);

    // JK update: 00 hold, 01 clear, 10 set, 11 invert.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter giving requesters A and B exclusive, sequenced access
// to a bank of N JK flip-flops.
//
// Handshake: a command transfers on a rising edge where valid and ready are
// both high. ready is only raised in IDLE and only for the single granted
// requester; a requester keeps valid/idx/op stable until it sees ready, so a
// low ready never loses a request.
module jk_bank_arbiter
    import jk_bank_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          a_valid,
    input  logic          b_valid,
    output logic          a_ready,
    output logic          b_ready,
    input  logic [IW-1:0] a_idx,
    input  logic [IW-1:0] b_idx,
    input  logic [1:0]    a_op,
    input  logic [1:0]    b_op,
    output logic [N-1:0]  q,
    output logic          done,
    output logic          done_id,
    output jk_state_t     state_dbg
);

    jk_state_t     state;
    jk_state_t     state_nxt;
    logic          grant_a;
    logic          grant_b;
    logic          prefer_b;   // round-robin pointer: 1 when B wins a tie
    logic          owner;      // requester of the command in flight
    logic [IW-1:0] cap_idx;
    jk_op_t        cap_op;
    logic [N-1:0]  j_vec;
    logic [N-1:0]  k_vec;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant selection and next-state; ready is held low while in reset.
    always_comb begin
        state_nxt = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (reset_n && a_valid && (!b_valid || !prefer_b)) begin
                    grant_a = 1'b1;
                end else if (reset_n && b_valid) begin
                    grant_b = 1'b1;
                end
                if (grant_a || grant_b) begin
                    state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Capture the granted command and advance the round-robin pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_idx  <= '0;
            cap_op   <= OP_HOLD;
            owner    <= REQ_A;
            prefer_b <= 1'b0;
        end else if (grant_a) begin
            cap_idx  <= a_idx;
            cap_op   <= jk_op_t'(a_op);
            owner    <= REQ_A;
            prefer_b <= 1'b1;
        end else if (grant_b) begin
            cap_idx  <= b_idx;
            cap_op   <= jk_op_t'(b_op);
            owner    <= REQ_B;
            prefer_b <= 1'b0;
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign done      = (state == ST_DONE);
    assign done_id   = done & owner;
    assign state_dbg = state;

    // One JK cell per bank bit; only the captured index sees a non-hold op,
    // and only for the single APPLY cycle. An index >= N matches no cell.
    for (genvar g = 0; g < N; g++) begin : g_cell
        assign j_vec[g] = (state == ST_APPLY) && (cap_idx == IW'(g)) && cap_op[1];
        assign k_vec[g] = (state == ST_APPLY) && (cap_idx == IW'(g)) && cap_op[0];

        jk_ff_cell u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .j       (j_vec[g]),
            .k       (k_vec[g]),
            .q       (q[g])
        );
    end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter (N=8, IW=4 so out-of-range indices can be driven).
module tb_jk_bank_arbiter;
    import jk_bank_pkg::*;

    localparam int N  = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [IW-1:0] a_idx, b_idx;
    logic [1:0]    a_op, b_op;
    logic [N-1:0]  q;
    logic          done, done_id;
    jk_state_t     state_dbg;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int c0;

    jk_bank_arbiter #(.N(N), .IW(IW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .a_ready   (a_ready),
        .b_ready   (b_ready),
        .a_idx     (a_idx),
        .b_idx     (b_idx),
        .a_op      (a_op),
        .b_op      (b_op),
        .q         (q),
        .done      (done),
        .done_id   (done_id),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Count done pulses and check that done/a_ready/b_ready are mutually exclusive.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (done === 1'b1) done_cnt++;
            chk("mutex", 32'(int'(done) + int'(a_ready) + int'(b_ready) <= 1), 32'd1);
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_done_id", 32'(done_id), 32'h0);
        chk("rst_ready", 32'({a_ready, b_ready}), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // One full command from a single requester: grant, APPLY, DONE, back to IDLE.
    task automatic run_cmd(input logic is_b, input logic [IW-1:0] idx, input logic [1:0] op,
                           input logic [N-1:0] exp_q);
        if (is_b) begin b_valid = 1'b1; b_idx = idx; b_op = op; end
        else      begin a_valid = 1'b1; a_idx = idx; a_op = op; end
        #1;
        chk("grant_ready", 32'({a_ready, b_ready}), is_b ? 32'h1 : 32'h2);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        chk("apply_state", 32'(state_dbg), 32'(ST_APPLY));
        chk("apply_ready", 32'({a_ready, b_ready}), 32'h0);
        chk("apply_done", 32'(done), 32'h0);
        @(posedge clk); #1;
        chk("done_q", 32'(q), 32'(exp_q));
        chk("done_pulse", 32'(done), 32'h1);
        chk("done_id", 32'(done_id), 32'(is_b));
        @(posedge clk); #1;
        chk("idle_done", 32'(done), 32'h0);
        chk("idle_state", 32'(state_dbg), 32'(ST_IDLE));
    endtask

    initial begin
        reset_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        a_idx = '0; b_idx = '0; a_op = 2'b00; b_op = 2'b00;

        // Ready stays low during reset even with a request present.
        a_valid = 1'b1; a_idx = 4'd3; a_op = OP_SET;
        @(posedge clk); #1;
        chk("rst_ready_gated", 32'({a_ready, b_ready}), 32'h0);
        a_valid = 1'b0;
        do_reset();

        // Single A set idx 3 straight after reset.
        run_cmd(1'b0, 4'd3, OP_SET, 8'h08);

        // Both valid after reset: A first, B three cycles later.
        do_reset();
        a_valid = 1'b1; a_idx = 4'd0; a_op = OP_SET;
        b_valid = 1'b1; b_idx = 4'd1; b_op = OP_SET;
        #1;
        chk("rr_first", 32'({a_ready, b_ready}), 32'h2);
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk("rr_b_held", 32'(b_ready), 32'h0);
        @(posedge clk); #1;
        chk("rr_q_a", 32'(q), 32'h01);
        chk("rr_done_a", 32'({done, done_id}), 32'h2);
        chk("rr_b_wait", 32'(b_ready), 32'h0);
        @(posedge clk); #1;
        chk("rr_second", 32'({a_ready, b_ready}), 32'h1);
        @(posedge clk); #1;
        b_valid = 1'b0;
        @(posedge clk); #1;
        chk("rr_q_b", 32'(q), 32'h03);
        chk("rr_done_b", 32'({done, done_id}), 32'h3);
        @(posedge clk); #1;

        // Both valid again: last grant was B, so A wins.
        a_valid = 1'b1; a_idx = 4'd2; a_op = OP_SET;
        b_valid = 1'b1; b_idx = 4'd4; b_op = OP_SET;
        #1;
        chk("rr_after_b", 32'({a_ready, b_ready}), 32'h2);
        a_valid = 1'b0; b_valid = 1'b0;
        #1;

        // B toggles idx 7 twice from zero: exactly one inversion per command.
        do_reset();
        c0 = done_cnt;
        run_cmd(1'b1, 4'd7, OP_TOGGLE, 8'h80);
        run_cmd(1'b1, 4'd7, OP_TOGGLE, 8'h00);
        chk("toggle_done_cnt", 32'(done_cnt - c0), 32'd2);

        // Fill the bank, then a hold op leaves it unchanged but still completes.
        for (int i = 0; i < N; i++) begin
            run_cmd(1'b0, IW'(i), OP_SET, N'((1 << (i + 1)) - 1));
        end
        c0 = done_cnt;
        run_cmd(1'b0, 4'd2, OP_HOLD, 8'hFF);
        chk("hold_done_cnt", 32'(done_cnt - c0), 32'd1);

        // Out-of-range index: sequenced with done, no bank change; next command normal.
        c0 = done_cnt;
        run_cmd(1'b0, 4'd9, OP_RESET, 8'hFF);
        chk("oor_done_cnt", 32'(done_cnt - c0), 32'd1);
        run_cmd(1'b0, 4'd1, OP_RESET, 8'hFD);

        // Reset during APPLY aborts without done; held request is re-granted.
        do_reset();
        a_valid = 1'b1; a_idx = 4'd5; a_op = OP_SET;
        #1;
        chk("abort_grant", 32'(a_ready), 32'h1);
        @(posedge clk); #1;
        chk("abort_in_apply", 32'(state_dbg), 32'(ST_APPLY));
        c0 = done_cnt;
        reset_n = 1'b0;
        #1;
        chk("abort_q", 32'(q), 32'h0);
        chk("abort_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("abort_ready", 32'(a_ready), 32'h0);
        @(posedge clk); #1;
        chk("abort_no_done", 32'(done), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("abort_no_done_cnt", 32'(done_cnt - c0), 32'd0);
        run_cmd(1'b0, 4'd5, OP_SET, 8'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
